pwm_dt_gen: RTL and testbench
=============================

# pwm_dt_gen

Dead-time-aware PWM generator directly downstream of `pid`. It consumes the controller's signed `out` word, adds a programmable offset, and clamps the result into the current PWM period. It produces a complementary high-side/low-side gate pair with programmable dead time. Duty is sampled once per period so the `pid` output may change freely at any cycle.

## Interface
Parameters:
- D_WIDTH, 16, width of `duty_in` (matches `pid` D_WIDTH); two's complement
- CNT_WIDTH, 16, width of period counter and period register
- DT_WIDTH, 8, width of dead-time register

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- write_enable  in  1  active-low register write strobe, same protocol as `pid`
- reg_addr  in  16  register address
- reg_data  in  16  register write data
- duty_in  in  D_WIDTH  signed duty command, connected to `pid.out`
- pwm_h  out  1  high-side gate
- pwm_l  out  1  low-side gate
- period_start  out  1  one-cycle pulse on the cycle the counter is 0
- duty_active  out  CNT_WIDTH  clamped duty currently in use

## Operation
- Register map, written on a rising edge with write_enable=0; other addresses are ignored:
  - 0 PERIOD: reset value 100.
  - 1 DEADTIME: low DT_WIDTH bits; reset value 0.
  - 2 OFFSET: signed; reset value 0.
  - 3 CTRL: bit0 enable, bit1 swap h/l; reset value 0.
- PERIOD is shadowed and takes effect at the next wrap. DEADTIME, OFFSET and CTRL take effect the next cycle.
- Counter: runs 0..period_shadow, wrapping to 0. One PWM cycle is period+1 clocks. PERIOD=0 means every cycle is a boundary.
- Duty latch: on the cycle counter==period_shadow, latch d = sign-extended duty_in + OFFSET.
  - Use a (max(D_WIDTH,16)+1)-bit signed sum so the addition cannot overflow.
  - Clamp d to [0, new period+1]; the new period is the PERIOD value being loaded in the same cycle.
  - Store the result in duty_active.
- Raw compare: raw = (counter < duty_active). Duty 0 means raw is never 1; duty period+1 means raw is always 1.
- Gate FSM states: OFF, H_ON, DEAD, L_ON.
  - OFF: both gates low. While enable=0 the FSM is held in OFF and the counter is held at 0. When enable rises, go to DEAD.
  - H_ON: pwm_h=1. When raw=0, go to DEAD.
  - L_ON: pwm_l=1. When raw=1, go to DEAD.
  - DEAD: both gates low for DEADTIME cycles, then enter H_ON if raw=1, else L_ON. A raw toggle during DEAD does not restart the count.
  - DEADTIME=0: DEAD lasts zero cycles and the FSM goes straight to the opposite ON state.
- Swap bit exchanges the pwm_h/pwm_l pins after the FSM.
- pwm_h and pwm_l are never both 1 under any register sequence.

## Timing
- Reset values: pwm_h=0, pwm_l=0, period_start=0, duty_active=0, counter=0, FSM=OFF.
- Gate outputs are registered, one cycle after the counter value that caused them.
- period_start is registered, aligned with the gate outputs for counter=0.
- First enable after reset: the counter starts at 0 and duty_active=0, so the first period is low side only after dead time.
- Enable falling: both gates go low on the next clock and the counter returns to 0.
- Reset asserted mid-period: gates drop immediately (asynchronously), and all registers return to their reset values.
- Write to PERIOD and wrap in the same cycle: the newly written value is used.
- duty_in is sampled only at the wrap cycle; all other cycles ignore it.

## Structure
- Shared package `pid_pkg`: register address constants (including the 0..3 map for this block), CTRL bit indices, gate FSM state enum.
- Sub-module `dead_time_fsm`: takes raw, enable and deadtime as inputs; drives the h/l outputs.
- Register file, counter, and duty latch/clamp live in the top module.

## Test plan
- Reset, PERIOD=9, DEADTIME=0, enable, duty_in=5 -> from the second period onward, pwm_h high 5 of every 10 cycles and pwm_l high 5.
- DEADTIME=2, duty_in=5, PERIOD=9 -> each edge has exactly 2 cycles with both gates low; pwm_h high 3, pwm_l high 3.
- duty_in=-20 (OFFSET=0) -> duty_active=0, pwm_h never high. duty_in=500 -> duty_active=10, pwm_l never high after the first dead gap.
- OFFSET=3, duty_in=2, PERIOD=9 -> duty_active=5. PERIOD changed to 19 mid-period -> the current period still wraps at 9 and the next is 20 cycles long.
- duty_in changes every cycle -> duty_active changes only at period_start boundaries.
- Reset pulled low mid-H_ON -> pwm_h=0 without waiting for a clock. Enable cleared -> both gates 0 next cycle. A random register/duty sweep never shows pwm_h & pwm_l = 1.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared definitions for the pid loop and its downstream PWM stage:
// register map, CTRL bit positions and the gate FSM state encoding.
package pid_pkg;

  localparam logic [15:0] PWM_ADDR_PERIOD   = 16'd0;
  localparam logic [15:0] PWM_ADDR_DEADTIME = 16'd1;
  localparam logic [15:0] PWM_ADDR_OFFSET   = 16'd2;
  localparam logic [15:0] PWM_ADDR_CTRL     = 16'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_SWAP_BIT = 1;

  localparam int PWM_PERIOD_RST = 100;

  typedef enum logic [1:0] {
    GATE_OFF  = 2'd0,
    GATE_H_ON = 2'd1,
    GATE_DEAD = 2'd2,
    GATE_L_ON = 2'd3
  } gate_state_e;

endpackage

// File: rtl/dead_time_fsm.sv
// Complementary gate sequencer: follows raw, inserting a dead-time gap of
// `deadtime` cycles with both gates low on every side change.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   GATE_OFF  | disabled, both gates low
//   GATE_H_ON | high-side gate on
//   GATE_DEAD | both gates low, dead-time down-counter running
//   GATE_L_ON | low-side gate on
module dead_time_fsm
  import pid_pkg::*;
#(
  parameter int DT_WIDTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                raw,
  input  logic                enable,
  input  logic [DT_WIDTH-1:0] deadtime,
  output logic                gate_h,
  output logic                gate_l
);

  gate_state_e         state_q, state_d;
  logic [DT_WIDTH-1:0] dcnt_q, dcnt_d;
  logic                h_q, h_d;
  logic                l_q, l_d;
  logic                leave;
  gate_state_e         target;

  always_comb begin
    target = raw ? GATE_H_ON : GATE_L_ON;
    leave  = (state_q == GATE_OFF) ||
             (state_q == GATE_H_ON && !raw) ||
             (state_q == GATE_L_ON && raw);
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    if (!enable) begin
      state_d = GATE_OFF;
      dcnt_d  = '0;
    end else if (state_q == GATE_DEAD) begin
      // the count was loaded on entry, so raw toggles here never extend it
      if (dcnt_q <= DT_WIDTH'(1)) state_d = target;
      else                        dcnt_d  = dcnt_q - DT_WIDTH'(1);
    end else if (leave) begin
      if (deadtime == '0) begin
        state_d = target;
      end else begin
        state_d = GATE_DEAD;
        dcnt_d  = deadtime;
      end
    end
    h_d = (state_d == GATE_H_ON);
    l_d = (state_d == GATE_L_ON);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= GATE_OFF;
      dcnt_q  <= '0;
      h_q     <= 1'b0;
      l_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      h_q     <= h_d;
      l_q     <= l_d;
    end
  end

  assign gate_h = h_q;
  assign gate_l = l_q;

endmodule

// File: rtl/pwm_dt_gen.sv
// Dead-time-aware PWM generator fed by the pid output: register file,
// period counter with shadowed period, and once-per-period duty latch/clamp.
module pwm_dt_gen
  import pid_pkg::*;
#(
  parameter int D_WIDTH   = 16,
  parameter int CNT_WIDTH = 16,
  parameter int DT_WIDTH  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 write_enable,
  input  logic [15:0]          reg_addr,
  input  logic [15:0]          reg_data,
  input  logic [D_WIDTH-1:0]   duty_in,
  output logic                 pwm_h,
  output logic                 pwm_l,
  output logic                 period_start,
  output logic [CNT_WIDTH-1:0] duty_active
);

  localparam int SUM_W = ((D_WIDTH > 16) ? D_WIDTH : 16) + 1;
  localparam int W     = (SUM_W > CNT_WIDTH + 2) ? SUM_W : CNT_WIDTH + 2;

  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] shadow_q, shadow_d;
  logic [DT_WIDTH-1:0]  deadtime_q, deadtime_d;
  logic [15:0]          offset_q, offset_d;
  logic [1:0]           ctrl_q, ctrl_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH:0]   duty_q, duty_d;
  logic                 pstart_q, pstart_d;

  logic                 wr;
  logic                 enable;
  logic [CNT_WIDTH-1:0] new_period;
  logic [W-1:0]         sum_w;
  logic [W-1:0]         upper_w;
  logic [CNT_WIDTH:0]   duty_clamped;
  logic                 raw;
  logic                 gate_h;
  logic                 gate_l;

  assign wr     = !write_enable;
  assign enable = ctrl_q[CTRL_EN_BIT];
  assign raw    = ({1'b0, cnt_q} < duty_q);

  // a PERIOD write landing on the wrap cycle must be the one picked up
  always_comb begin
    new_period = period_q;
    if (wr && reg_addr == PWM_ADDR_PERIOD) new_period = CNT_WIDTH'(reg_data);
  end

  always_comb begin
    sum_w   = {{(W-D_WIDTH){duty_in[D_WIDTH-1]}}, duty_in} +
              {{(W-16){offset_q[15]}}, offset_q};
    upper_w = W'({1'b0, new_period}) + W'(1);
    if (sum_w[W-1])            duty_clamped = '0;
    else if (sum_w > upper_w)  duty_clamped = upper_w[CNT_WIDTH:0];
    else                       duty_clamped = sum_w[CNT_WIDTH:0];
  end

  always_comb begin
    period_d   = period_q;
    deadtime_d = deadtime_q;
    offset_d   = offset_q;
    ctrl_d     = ctrl_q;
    if (wr) begin
      case (reg_addr)
        PWM_ADDR_PERIOD:   period_d   = CNT_WIDTH'(reg_data);
        PWM_ADDR_DEADTIME: deadtime_d = reg_data[DT_WIDTH-1:0];
        PWM_ADDR_OFFSET:   offset_d   = reg_data;
        PWM_ADDR_CTRL:     ctrl_d     = reg_data[1:0];
        default:           ;
      endcase
    end

    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    duty_d   = duty_q;
    if (!enable) begin
      // idle sits on a boundary: next enable starts fresh with duty 0
      cnt_d    = '0;
      shadow_d = new_period;
      duty_d   = '0;
    end else if (cnt_q == shadow_q) begin
      cnt_d    = '0;
      shadow_d = new_period;
      duty_d   = duty_clamped;
    end else begin
      cnt_d    = cnt_q + CNT_WIDTH'(1);
    end

    pstart_d = enable && (cnt_q == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      period_q   <= CNT_WIDTH'(PWM_PERIOD_RST);
      shadow_q   <= CNT_WIDTH'(PWM_PERIOD_RST);
      deadtime_q <= '0;
      offset_q   <= '0;
      ctrl_q     <= '0;
      cnt_q      <= '0;
      duty_q     <= '0;
      pstart_q   <= 1'b0;
    end else begin
      period_q   <= period_d;
      shadow_q   <= shadow_d;
      deadtime_q <= deadtime_d;
      offset_q   <= offset_d;
      ctrl_q     <= ctrl_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      pstart_q   <= pstart_d;
    end
  end

  dead_time_fsm #(
    .DT_WIDTH (DT_WIDTH)
  ) u_fsm (
    .clock    (clock),
    .reset    (reset),
    .raw      (raw),
    .enable   (enable),
    .deadtime (deadtime_q),
    .gate_h   (gate_h),
    .gate_l   (gate_l)
  );

  // swap muxes two flop outputs, so the pins stay mutually exclusive
  assign pwm_h        = ctrl_q[CTRL_SWAP_BIT] ? gate_l : gate_h;
  assign pwm_l        = ctrl_q[CTRL_SWAP_BIT] ? gate_h : gate_l;
  assign period_start = pstart_q;
  // full-period duty (period+1) may not fit the port at maximum period
  assign duty_active  = duty_q[CNT_WIDTH] ? '1 : duty_q[CNT_WIDTH-1:0];

endmodule

// File: tb/tb_pwm_dt_gen.sv
// Directed and swept bench for pwm_dt_gen against a cycle model built from
// the register/counter/dead-time rules, plus hand-computed window checks.
module tb_pwm_dt_gen;

  logic        clock;
  logic        reset;
  logic        write_enable;
  logic [15:0] reg_addr;
  logic [15:0] reg_data;
  logic [15:0] duty_in;
  logic        pwm_h;
  logic        pwm_l;
  logic        period_start;
  logic [15:0] duty_active;

  int total = 0;
  int bad   = 0;

  pwm_dt_gen dut (
    .clock        (clock),
    .reset        (reset),
    .write_enable (write_enable),
    .reg_addr     (reg_addr),
    .reg_data     (reg_data),
    .duty_in      (duty_in),
    .pwm_h        (pwm_h),
    .pwm_l        (pwm_l),
    .period_start (period_start),
    .duty_active  (duty_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: side 0 = none, 1 = high side, 2 = low side
  int m_period, m_shadow, m_dt, m_off, m_cnt, m_duty, m_side, m_blank;
  int m_en, m_swap, m_newp, m_want, m_raw, m_d;
  int e_h, e_l, e_ps, e_duty;
  logic m_wr;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_period = 100; m_shadow = 100; m_dt = 0; m_off = 0;
      m_en = 0; m_swap = 0; m_cnt = 0; m_duty = 0;
      m_side = 0; m_blank = 0;
      e_h = 0; e_l = 0; e_ps = 0; e_duty = 0;
    end else begin
      m_wr   = (write_enable == 1'b0);
      m_newp = (m_wr && reg_addr == 16'd0) ? int'(reg_data) : m_period;
      m_raw  = (m_cnt < m_duty) ? 1 : 0;
      m_want = m_raw ? 1 : 2;

      if (m_en == 0) begin
        m_side = 0; m_blank = 0;
      end else if (m_blank > 0) begin
        m_blank = m_blank - 1;
        if (m_blank == 0) m_side = m_want;
      end else if (m_side != m_want) begin
        if (m_dt == 0) m_side = m_want;
        else begin m_side = 0; m_blank = m_dt; end
      end

      e_ps = (m_en != 0 && m_cnt == 0) ? 1 : 0;

      if (m_en == 0) begin
        m_cnt = 0; m_shadow = m_newp; m_duty = 0;
      end else if (m_cnt == m_shadow) begin
        m_cnt = 0; m_shadow = m_newp;
        m_d = int'(signed'(duty_in)) + m_off;
        if (m_d < 0) m_d = 0;
        if (m_d > m_newp + 1) m_d = m_newp + 1;
        m_duty = m_d;
      end else begin
        m_cnt = m_cnt + 1;
      end

      if (m_wr) begin
        case (reg_addr)
          16'd0: m_period = int'(reg_data);
          16'd1: m_dt     = int'(reg_data) % 256;
          16'd2: m_off    = int'(signed'(reg_data));
          16'd3: begin m_en = int'(reg_data[0]); m_swap = int'(reg_data[1]); end
          default: ;
        endcase
      end

      e_h    = m_swap ? ((m_side == 2) ? 1 : 0) : ((m_side == 1) ? 1 : 0);
      e_l    = m_swap ? ((m_side == 1) ? 1 : 0) : ((m_side == 2) ? 1 : 0);
      e_duty = (m_duty > 65535) ? 65535 : m_duty;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      chk("pwm_h", int'(pwm_h), e_h);
      chk("pwm_l", int'(pwm_l), e_l);
      chk("period_start", int'(period_start), e_ps);
      chk("duty_active", int'(duty_active), e_duty);
      chk("overlap", int'(pwm_h & pwm_l), 0);
    end
  end

  task automatic wr_reg(input logic [15:0] a, input logic [15:0] d);
    @(negedge clock);
    write_enable = 1'b0; reg_addr = a; reg_data = d;
    @(negedge clock);
    write_enable = 1'b1;
  endtask

  task automatic win(input int n, output int nh, output int nl, output int nz);
    nh = 0; nl = 0; nz = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      nh += int'(pwm_h);
      nl += int'(pwm_l);
      nz += int'(!pwm_h && !pwm_l);
    end
  endtask

  task automatic wait_ps(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!period_start && n < budget);
    if (!period_start) chk("ps_timeout", 0, 1);
  endtask

  int nh, nl, nz, g, chg;
  logic [15:0] prev_duty;

  initial begin
    reset = 1'b0; write_enable = 1'b1; reg_addr = '0; reg_data = '0; duty_in = '0;
    repeat (3) @(negedge clock);
    chk("rst_pwm_h", int'(pwm_h), 0);
    chk("rst_pwm_l", int'(pwm_l), 0);
    chk("rst_period_start", int'(period_start), 0);
    chk("rst_duty_active", int'(duty_active), 0);
    reset = 1'b1;

    // PERIOD=9, DEADTIME=0, duty 5
    wr_reg(16'd0, 16'd9);
    wr_reg(16'd1, 16'd0);
    duty_in = 16'd5;
    wr_reg(16'd3, 16'd1);
    repeat (15) @(negedge clock);
    chk("lit_duty5", int'(duty_active), 5);
    win(10, nh, nl, nz);
    chk("dt0_h_count", nh, 5);
    chk("dt0_l_count", nl, 5);

    // DEADTIME=2
    wr_reg(16'd1, 16'd2);
    repeat (20) @(negedge clock);
    win(10, nh, nl, nz);
    chk("dt2_h_count", nh, 3);
    chk("dt2_l_count", nl, 3);
    chk("dt2_gap_count", nz, 4);

    // clamp low and high
    duty_in = 16'hFFEC;
    repeat (25) @(negedge clock);
    chk("lit_clamp_lo", int'(duty_active), 0);
    win(10, nh, nl, nz);
    chk("clamp_lo_h", nh, 0);
    duty_in = 16'd500;
    repeat (25) @(negedge clock);
    chk("lit_clamp_hi", int'(duty_active), 10);
    win(10, nh, nl, nz);
    chk("clamp_hi_l", nl, 0);

    // offset, then PERIOD change mid-period
    wr_reg(16'd2, 16'd3);
    duty_in = 16'd2;
    repeat (25) @(negedge clock);
    chk("lit_offset", int'(duty_active), 5);
    wait_ps(40);
    write_enable = 1'b0; reg_addr = 16'd0; reg_data = 16'd19;
    @(negedge clock);
    write_enable = 1'b1;
    g = 1;
    while (!period_start && g < 100) begin @(negedge clock); g++; end
    chk("gap_old_period", g, 10);
    g = 0;
    do begin @(negedge clock); g++; end while (!period_start && g < 100);
    chk("gap_new_period", g, 20);

    // duty_in moving every cycle
    wr_reg(16'd2, 16'd0);
    wr_reg(16'd0, 16'd9);
    wait_ps(60);
    wait_ps(60);
    chg = 0;
    prev_duty = duty_active;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      duty_in = 16'(1 + (i % 8));
      if (duty_active != prev_duty) chg++;
      prev_duty = duty_active;
    end
    chk("duty_changes_le4", (chg <= 4) ? 1 : 0, 1);

    // swap
    wr_reg(16'd3, 16'd3);
    repeat (20) @(negedge clock);
    wr_reg(16'd3, 16'd1);

    // register/duty sweep
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      write_enable = ($urandom_range(0, 3) != 0);
      reg_addr = 16'($urandom_range(0, 5));
      case (reg_addr)
        16'd0: reg_data = 16'($urandom_range(0, 15));
        16'd1: reg_data = 16'($urandom_range(0, 5));
        16'd2: reg_data = 16'(int'($urandom_range(0, 16)) - 8);
        16'd3: reg_data = {14'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0)};
        default: reg_data = 16'($urandom);
      endcase
      duty_in = 16'(int'($urandom_range(0, 60)) - 20);
    end
    write_enable = 1'b1;

    // enable falling
    wr_reg(16'd0, 16'd9);
    wr_reg(16'd1, 16'd0);
    wr_reg(16'd2, 16'd0);
    duty_in = 16'd500;
    wr_reg(16'd3, 16'd1);
    repeat (25) @(negedge clock);
    chk("lit_h_on", int'(pwm_h), 1);
    wr_reg(16'd3, 16'd0);
    @(negedge clock);
    chk("dis_h", int'(pwm_h), 0);
    chk("dis_l", int'(pwm_l), 0);

    // asynchronous reset while high side is on
    wr_reg(16'd3, 16'd1);
    repeat (25) @(negedge clock);
    chk("lit_h_on2", int'(pwm_h), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_h", int'(pwm_h), 0);
    chk("async_rst_duty", int'(duty_active), 0);
    repeat (2) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
